hermes_traffic_injector: RTL and testbench

- Packet transmitter for one Hermes link; the source end of the header/size/payload protocol that the traffic monitors decode.
- Accepts one packet descriptor at a time and serialises it into flits on the tx/credit/data interface: header, size, service, task_id, cons_id, then a generated payload.
- Used in simulation benches and stress tests to drive router ports with controlled traffic. Reports per-packet completion, stall count and start timestamp.

---
 rtl/hermes_traffic_injector_pkg.sv | 17 +
 rtl/hermes_traffic_injector.sv | 109 ++++++++++
 tb/tb_hermes_traffic_injector.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/hermes_traffic_injector_pkg.sv
// hermes_traffic_injector_pkg: FSM encoding and packet layout constants
package hermes_traffic_injector_pkg;
  localparam logic [2:0] OFF_SERVICE = 3'd2;
  localparam logic [2:0] OFF_TASK = 3'd3;
  localparam logic [2:0] OFF_CONS = 3'd4;
  localparam logic [31:0] FIXED_FIELDS = 32'd3;
  // state codes double as flit offsets for the fixed fields
  typedef enum logic [2:0] {
    S_HEADER  = 3'd0,
    S_SIZE    = 3'd1,
    S_SERVICE = OFF_SERVICE,
    S_TASK    = OFF_TASK,
    S_CONS    = OFF_CONS,
    S_PAYLOAD = 3'd5,
    S_IDLE    = 3'd7
  } state_t;
endpackage

// File: rtl/hermes_traffic_injector.sv
// hermes_traffic_injector: serialises one packet descriptor into Hermes flits with completion stats
module hermes_traffic_injector
  import hermes_traffic_injector_pkg::*;
#(
  parameter int FLIT_SIZE = 32,
  parameter int MAX_PAYLOAD = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 ready_o,
  input  logic [15:0]          target_i,
  input  logic [31:0]          service_i,
  input  logic [15:0]          task_id_i,
  input  logic [15:0]          cons_id_i,
  input  logic [15:0]          payload_len_i,
  input  logic [FLIT_SIZE-1:0] seed_i,
  input  logic [63:0]          tick_cntr_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [63:0]          header_time_o,
  output logic [31:0]          stall_cycles_o,
  output logic [31:0]          pkt_cntr_o
);
  state_t r_state, w_next;
  logic [15:0] r_target, r_task, r_cons, r_len, r_idx;
  logic [31:0] r_service, r_stall, r_pkt_cntr;
  logic [FLIT_SIZE-1:0] r_seed;
  logic [63:0] r_header_time;
  logic r_done, r_err;
  logic w_busy, w_xfer, w_accept, w_reject, w_last;
  assign w_busy = r_state != S_IDLE;
  assign w_xfer = w_busy && credit_i;
  assign w_accept = !w_busy && req_i && (32'(payload_len_i) <= 32'(MAX_PAYLOAD));
  assign w_reject = !w_busy && req_i && !w_accept;
  assign w_last = (r_state == S_CONS && r_len == 16'd0) ||
                  (r_state == S_PAYLOAD && r_idx == r_len - 16'd1);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_target <= '0;
      r_service <= '0;
      r_task <= '0;
      r_cons <= '0;
      r_len <= '0;
      r_seed <= '0;
      r_idx <= '0;
      r_stall <= '0;
      r_pkt_cntr <= '0;
      r_header_time <= '0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done <= w_xfer && w_last;
      r_err <= w_reject;
      if (w_accept) begin
        r_target <= target_i;
        r_service <= service_i;
        r_task <= task_id_i;
        r_cons <= cons_id_i;
        r_len <= payload_len_i;
        r_seed <= seed_i;
        r_idx <= '0;
        r_stall <= '0;
      end else if (w_busy && !credit_i && r_stall != '1) begin
        r_stall <= r_stall + 32'd1;
      end
      if (w_xfer && r_state == S_PAYLOAD) r_idx <= r_idx + 16'd1;
      if (w_xfer && r_state == S_HEADER) r_header_time <= tick_cntr_i;
      if (w_xfer && w_last) r_pkt_cntr <= r_pkt_cntr + 32'd1;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = w_accept ? S_HEADER : S_IDLE;
      S_HEADER:  w_next = credit_i ? S_SIZE : S_HEADER;
      S_SIZE:    w_next = credit_i ? S_SERVICE : S_SIZE;
      S_SERVICE: w_next = credit_i ? S_TASK : S_SERVICE;
      S_TASK:    w_next = credit_i ? S_CONS : S_TASK;
      S_CONS:    w_next = credit_i ? (w_last ? S_IDLE : S_PAYLOAD) : S_CONS;
      S_PAYLOAD: w_next = (credit_i && w_last) ? S_IDLE : S_PAYLOAD;
      default:   w_next = S_IDLE;
    endcase
  end
  always_comb begin
    data_o = '0;
    case (r_state)
      S_HEADER:  data_o = FLIT_SIZE'(r_target);
      S_SIZE:    data_o = FLIT_SIZE'(FIXED_FIELDS + 32'(r_len));
      S_SERVICE: data_o = FLIT_SIZE'(r_service);
      S_TASK:    data_o = FLIT_SIZE'(r_task);
      S_CONS:    data_o = FLIT_SIZE'(r_cons);
      S_PAYLOAD: data_o = r_seed + FLIT_SIZE'(r_idx);
      default:   data_o = '0;
    endcase
  end
  assign ready_o = !w_busy;
  assign tx_o = w_busy;
  assign done_o = r_done;
  assign err_o = r_err;
  assign header_time_o = r_header_time;
  assign stall_cycles_o = r_stall;
  assign pkt_cntr_o = r_pkt_cntr;
endmodule

// File: tb/tb_hermes_traffic_injector.sv
// tb_hermes_traffic_injector: directed self-checking bench for the Hermes packet injector
module tb_hermes_traffic_injector;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, credit = 1'b1;
  logic [15:0] target = '0, task_id = '0, cons_id = '0, plen = '0;
  logic [31:0] service = '0, seed = '0;
  logic [63:0] tick = '0;
  logic ready, tx, done, err;
  logic [31:0] data, stall, pkt;
  logic [63:0] htime;
  int checks = 0, errors = 0;

  hermes_traffic_injector #(.FLIT_SIZE(32), .MAX_PAYLOAD(1024)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .ready_o(ready),
    .target_i(target), .service_i(service), .task_id_i(task_id), .cons_id_i(cons_id),
    .payload_len_i(plen), .seed_i(seed), .tick_cntr_i(tick),
    .tx_o(tx), .credit_i(credit), .data_o(data), .done_o(done), .err_o(err),
    .header_time_o(htime), .stall_cycles_o(stall), .pkt_cntr_o(pkt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic flit(input string tag, input logic [31:0] exp, input int stalls);
    for (int i = 0; i < stalls; i++) begin
      credit = 1'b0;
      chk({tag, "_stall"}, {tx, data}, {1'b1, exp});
      @(negedge clk);
    end
    credit = 1'b1;
    chk(tag, {tx, data}, {1'b1, exp});
    @(negedge clk);
  endtask

  task automatic start(input logic [15:0] t, input logic [31:0] s, input logic [15:0] tk,
                       input logic [15:0] c, input logic [15:0] l, input logic [31:0] sd);
    target = t; service = s; task_id = tk; cons_id = c; plen = l; seed = sd; req = 1'b1;
    chk("ready_before_accept", ready, 1);
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic fixed(input logic [15:0] t, input logic [31:0] s, input logic [15:0] tk,
                       input logic [15:0] c, input logic [15:0] l);
    flit("header", 32'(t), 0);
    flit("size", 32'd3 + 32'(l), 0);
    flit("service", s, 0);
    flit("task", 32'(tk), 0);
    flit("cons", 32'(c), 0);
  endtask

  task automatic finish_pkt(input logic [31:0] exp_pkt, input logic [31:0] exp_stall);
    chk("done_pulse", done, 1);
    chk("done_ready", ready, 1);
    chk("done_tx", tx, 0);
    chk("pkt_cntr", pkt, 64'(exp_pkt));
    chk("stall_cycles", stall, 64'(exp_stall));
    @(negedge clk);
    chk("done_cleared", done, 0);
  endtask

  initial begin
    // reset values
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_tx", tx, 0);
    chk("rst_data", data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_htime", htime, 0);
    chk("rst_stall", stall, 0);
    chk("rst_pkt", pkt, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic packet: flits 102,5,10,5,9,A0,A1
    tick = 64'h1234_5678_9ABC_DEF0;
    start(16'h0102, 32'h10, 16'd5, 16'd9, 16'd2, 32'hA0);
    fixed(16'h0102, 32'h10, 16'd5, 16'd9, 16'd2);
    flit("pay0", 32'hA0, 0);
    flit("pay1", 32'hA1, 0);
    finish_pkt(1, 0);
    chk("basic_htime", htime, 64'h1234_5678_9ABC_DEF0);

    // zero payload: size flit 3, done straight after cons
    tick = 64'h77;
    start(16'h0007, 32'h20, 16'd1, 16'd2, 16'd0, 32'h0);
    fixed(16'h0007, 32'h20, 16'd1, 16'd2, 16'd0);
    finish_pkt(2, 0);
    chk("zero_htime", htime, 64'h77);

    // backpressure: 4 stalls in SIZE, 2 in second payload flit
    start(16'h0003, 32'h33, 16'd4, 16'd6, 16'd2, 32'h100);
    flit("bp_header", 32'h3, 0);
    flit("bp_size", 32'h5, 4);
    flit("bp_service", 32'h33, 0);
    flit("bp_task", 32'h4, 0);
    flit("bp_cons", 32'h6, 0);
    flit("bp_pay0", 32'h100, 0);
    flit("bp_pay1", 32'h101, 2);
    finish_pkt(3, 6);

    // reject oversize request
    target = 16'h0009; plen = 16'd1025; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    chk("rej_err", err, 1);
    chk("rej_tx", tx, 0);
    chk("rej_ready", ready, 1);
    chk("rej_pkt", pkt, 3);
    @(negedge clk);
    chk("rej_err_clear", err, 0);
    chk("rej_tx_still", tx, 0);

    // maximum payload accepted
    start(16'h0011, 32'h44, 16'd7, 16'd8, 16'd1024, 32'h0);
    fixed(16'h0011, 32'h44, 16'd7, 16'd8, 16'd1024);
    for (int i = 0; i < 1024; i++) flit("max_pay", 32'(i), 0);
    chk("max_no_err", err, 0);
    finish_pkt(4, 0);

    // seed wrap, req held high for back-to-back packets
    target = 16'h0201; service = 32'h55; task_id = 16'd2; cons_id = 16'd3;
    plen = 16'd2; seed = 32'hFFFF_FFFF; req = 1'b1;
    @(negedge clk);
    fixed(16'h0201, 32'h55, 16'd2, 16'd3, 16'd2);
    flit("wrap_pay0", 32'hFFFF_FFFF, 0);
    flit("wrap_pay1", 32'h0, 0);
    chk("b2b_done", done, 1);
    chk("b2b_idle_tx", tx, 0);
    chk("b2b_ready", ready, 1);
    chk("b2b_pkt", pkt, 5);
    seed = 32'h10;
    @(negedge clk);
    req = 1'b0;
    fixed(16'h0201, 32'h55, 16'd2, 16'd3, 16'd2);
    flit("b2b_pay0", 32'h10, 0);
    flit("b2b_pay1", 32'h11, 0);
    finish_pkt(6, 0);

    // reset during payload abandons the packet
    start(16'h0021, 32'h66, 16'd3, 16'd4, 16'd4, 32'h50);
    fixed(16'h0021, 32'h66, 16'd3, 16'd4, 16'd4);
    flit("mid_pay0", 32'h50, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_pkt", pkt, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_htime", htime, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tx", tx, 0);
    tick = 64'h42;
    start(16'h00AB, 32'h77, 16'd8, 16'd9, 16'd1, 32'h1234);
    fixed(16'h00AB, 32'h77, 16'd8, 16'd9, 16'd1);
    flit("fresh_pay0", 32'h1234, 0);
    finish_pkt(1, 0);
    chk("fresh_htime", htime, 64'h42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
